rr_bank_buffer: RTL and testbench

- N-bank rotating successor to the two-bank ping-pong buffer.
- Producer fills banks in round-robin order and consumer drains them in the same order; a wr_done/rd_done handshake passes bank ownership.
- An internal clear engine rewrites each drained bank to CLEAR_VAL before the producer may reuse it.
- Sits between a layer's result writer and the next layer's reader, as a generalisation of the fixed two-bank swap.

---
 rtl/rr_bank_buffer.sv | 174 +++++++++++++++++
 tb/tb_rr_bank_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bank_buffer.sv
// N-bank rotating buffer: the producer fills banks round-robin, the consumer drains them in the same order, and a sweep engine scrubs drained banks back to CLEAR_VAL.
// Latency: a write is readable the next cycle; read data and dout_valid are registered and appear 1 cycle after rd_en.
// Backpressure: wr_ready/rd_ready gate the ports; strobes and done pulses while not ready are dropped. Optional macro: RR_BUFFER_CLEAR_ON_RESET_EN.
module rr_bank_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    NUM_BANKS  = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0,
    localparam int                   BIDX_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_done,
    output logic                  wr_ready,
    output logic [BIDX_W-1:0]     wr_bank,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic [BIDX_W-1:0]     rd_bank,
    output logic                  clr_busy,
    output logic [BIDX_W:0]       full_cnt
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [BIDX_W-1:0] LAST_BANK = BIDX_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_FULL  = 2'd1,
        B_CLEAR = 2'd2
    } bank_st_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } clr_st_t;

    bank_st_t              bank_state [NUM_BANKS];
    clr_st_t               clr_state;
    logic [NUM_BANKS-1:0]  clr_mask;
    logic [NUM_BANKS-1:0]  clr_vec;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    logic wr_hand;
    logic rd_hand;
    logic wr_fire;
    logic sweep_last;

    assign wr_ready   = (bank_state[wr_bank] == B_EMPTY);
    assign rd_ready   = (bank_state[rd_bank] == B_FULL);
    assign clr_busy   = (clr_state == S_SWEEP);
    // clear overrides both handoffs and blocks producer writes for that cycle
    assign wr_hand    = wr_done && wr_ready && !clear;
    assign rd_hand    = rd_done && rd_ready && !clear;
    assign wr_fire    = wr_en && wr_ready && !clear;
    assign sweep_last = (clr_state == S_SWEEP) && (clr_cnt == {ADDR_WIDTH{1'b1}});

    // Flag every bank currently waiting to be scrubbed
    always_comb begin
        clr_vec = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            clr_vec[b] = (bank_state[b] == B_CLEAR);
        end
    end

    // Bank ownership, round-robin pointers, FULL count and the sweep FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef RR_BUFFER_CLEAR_ON_RESET_EN
                bank_state[b] <= B_CLEAR;
`else
                bank_state[b] <= B_EMPTY;
`endif
            end
            wr_bank   <= '0;
            rd_bank   <= '0;
            full_cnt  <= '0;
            clr_state <= S_IDLE;
            clr_mask  <= '0;
            clr_cnt   <= '0;
        end else begin
            if (clear) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    bank_state[b] <= B_CLEAR;
                end
                wr_bank  <= '0;
                rd_bank  <= '0;
                full_cnt <= '0;
            end else begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (sweep_last && clr_mask[b]) begin
                        bank_state[b] <= B_EMPTY;
                    end
                end
                // write bank is EMPTY and read bank is FULL, so these never collide
                if (wr_hand) begin
                    bank_state[wr_bank] <= B_FULL;
                    wr_bank             <= (wr_bank == LAST_BANK) ? '0 : wr_bank + 1'b1;
                end
                if (rd_hand) begin
                    bank_state[rd_bank] <= B_CLEAR;
                    rd_bank             <= (rd_bank == LAST_BANK) ? '0 : rd_bank + 1'b1;
                end
                case ({wr_hand, rd_hand})
                    2'b10:   full_cnt <= full_cnt + 1'b1;
                    2'b01:   full_cnt <= full_cnt - 1'b1;
                    default: full_cnt <= full_cnt;
                endcase
            end

            if (clear) begin
                // an in-flight sweep restarts over every bank; from IDLE the
                // next cycle latches the full mask on its own
                if (clr_state == S_SWEEP) begin
                    clr_cnt  <= '0;
                    clr_mask <= '1;
                end
            end else begin
                case (clr_state)
                    S_IDLE: begin
                        if (|clr_vec) begin
                            clr_state <= S_SWEEP;
                            clr_mask  <= clr_vec;
                            clr_cnt   <= '0;
                        end
                    end
                    S_SWEEP: begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (sweep_last) begin
                            clr_state <= S_IDLE;
                        end
                    end
                    default: clr_state <= S_IDLE;
                endcase
            end
        end
    end

    // Bank RAM writes: sweep engine on masked banks, producer on the write bank
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (clr_state == S_SWEEP && clr_mask[b]) begin
                mem[b][clr_cnt] <= CLEAR_VAL;
            end else if (wr_fire && wr_bank == BIDX_W'(b)) begin
                mem[b][wr_addr] <= din;
            end
        end
    end

    // Registered read port; dout holds its value when no read is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            dout_valid <= 1'b0;
        end else if (rd_en && rd_ready) begin
            dout       <= mem[rd_bank][rd_addr];
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_bank_buffer.sv
// Directed bench for rr_bank_buffer with 3 banks of 16 bytes each.
// Latency: inputs driven 1 ns after a rising edge, outputs sampled there too.
// Backpressure: exercises dropped writes/done pulses when no bank is free.
module tb_rr_bank_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] din;
    logic       wr_done;
    logic       wr_ready;
    logic [1:0] wr_bank;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       rd_done;
    logic       rd_ready;
    logic [1:0] rd_bank;
    logic       clr_busy;
    logic [2:0] full_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rr_bank_buffer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .NUM_BANKS (3),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .din       (din),
        .wr_done   (wr_done),
        .wr_ready  (wr_ready),
        .wr_bank   (wr_bank),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .dout      (dout),
        .dout_valid(dout_valid),
        .rd_done   (rd_done),
        .rd_ready  (rd_ready),
        .rd_bank   (rd_bank),
        .clr_busy  (clr_busy),
        .full_cnt  (full_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bank(input logic [7:0] base, input int n);
        for (int a = 0; a < n; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); din = base + 8'(a);
            tick();
        end
        wr_en = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic read_at(input logic [3:0] a, input logic done);
        rd_en = 1'b1; rd_addr = a; rd_done = done;
        tick();
        rd_en = 1'b0; rd_done = 1'b0;
    endtask

    // waits (bounded) for clr_busy, then counts consecutive busy cycles
    task automatic measure_busy(output int n, output int wr_rdy_seen);
        int w;
        n = 0; wr_rdy_seen = 0; w = 0;
        while (!clr_busy && w < 8) begin
            tick(); w++;
        end
        while (clr_busy && n < 64) begin
            if (wr_ready) wr_rdy_seen++;
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; din = '0;
        wr_done = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
        do_reset();

`ifdef RR_BUFFER_CLEAR_ON_RESET_EN
        check_eq("rst_sweep_busy0", clr_busy, 1'b0);
        check_eq("rst_sweep_wrrdy0", wr_ready, 1'b0);
        measure_busy(n, seen);
        check_eq("rst_sweep_len", n, 16);
        check_eq("rst_sweep_wrrdy_during", seen, 0);
        check_eq("rst_sweep_wrrdy_after", wr_ready, 1'b1);
        for (int b = 0; b < 3; b++) begin
            wr_done = 1'b1; tick(); wr_done = 1'b0;
        end
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < 16; a++) begin
                read_at(4'(a), 1'b0);
                check_eq($sformatf("rst_clr_b%0d_a%0d", b, a), dout, 8'h00);
            end
            rd_done = 1'b1; tick(); rd_done = 1'b0;
        end
        do_reset();
        measure_busy(n, seen);
        check_eq("rst2_sweep_len", n, 16);
`else
        check_eq("rst_wr_ready", wr_ready, 1'b1);
        check_eq("rst_rd_ready", rd_ready, 1'b0);
        check_eq("rst_wr_bank", wr_bank, 2'd0);
        check_eq("rst_rd_bank", rd_bank, 2'd0);
        check_eq("rst_full_cnt", full_cnt, 3'd0);
        check_eq("rst_clr_busy", clr_busy, 1'b0);
        check_eq("rst_dout_valid", dout_valid, 1'b0);
        check_eq("rst_dout", dout, 8'h00);
`endif

        // read while nothing is FULL is refused
        read_at(4'd0, 1'b0);
        check_eq("rd_notready_valid", dout_valid, 1'b0);

        // bank0: addr a holds 0x11+a for a=0..14
        fill_bank(8'h11, 15);
        check_eq("b0_full_cnt", full_cnt, 3'd1);
        check_eq("b0_wr_bank", wr_bank, 2'd1);
        check_eq("b0_rd_ready", rd_ready, 1'b1);
        read_at(4'd5, 1'b0);
        check_eq("b0_a5_dout", dout, 8'h16);
        check_eq("b0_a5_valid", dout_valid, 1'b1);
        check_eq("b0_rd_bank", rd_bank, 2'd0);
        tick();
        check_eq("idle_valid", dout_valid, 1'b0);
        check_eq("idle_dout_hold", dout, 8'h16);

        // fill the remaining banks; everything FULL
        fill_bank(8'h20, 16);
        fill_bank(8'h30, 16);
        check_eq("all_full_wr_ready", wr_ready, 1'b0);
        check_eq("all_full_cnt", full_cnt, 3'd3);
        check_eq("all_full_wr_bank", wr_bank, 2'd0);
        wr_en = 1'b1; wr_addr = 4'd0; din = 8'hEE; wr_done = 1'b1;
        tick();
        wr_en = 1'b0; wr_done = 1'b0;
        check_eq("drop_full_cnt", full_cnt, 3'd3);
        check_eq("drop_wr_bank", wr_bank, 2'd0);
        read_at(4'd0, 1'b0);
        check_eq("drop_data_kept", dout, 8'h11);

        // read together with rd_done, then bank0 is swept
        read_at(4'd2, 1'b1);
        check_eq("rddone_dout", dout, 8'h13);
        check_eq("rddone_valid", dout_valid, 1'b1);
        check_eq("rddone_rd_bank", rd_bank, 2'd1);
        check_eq("rddone_full_cnt", full_cnt, 3'd2);
        measure_busy(n, seen);
        check_eq("sweep_len", n, 16);
        check_eq("sweep_wr_ready", wr_ready, 1'b1);
        check_eq("sweep_full_cnt", full_cnt, 3'd2);

        // refill bank0 only at addr0
        fill_bank(8'h5A, 1);
        check_eq("refill_full_cnt", full_cnt, 3'd3);
        check_eq("refill_wr_bank", wr_bank, 2'd1);
        read_at(4'd4, 1'b1);
        check_eq("b1_a4_dout", dout, 8'h24);
        read_at(4'd15, 1'b1);
        check_eq("b2_a15_dout", dout, 8'h3F);
        check_eq("drain_rd_bank", rd_bank, 2'd0);
        check_eq("drain_full_cnt", full_cnt, 3'd1);
        for (int i = 0; i < 40; i++) tick();
        check_eq("drain_clr_busy", clr_busy, 1'b0);
        check_eq("drain_wr_ready", wr_ready, 1'b1);
        read_at(4'd3, 1'b0);
        check_eq("b0_a3_cleared", dout, 8'h00);
        read_at(4'd0, 1'b0);
        check_eq("b0_a0_refill", dout, 8'h5A);

        // bank1 gets one word, then wr_done and rd_done land together
        wr_en = 1'b1; wr_addr = 4'd9; din = 8'h77;
        tick();
        wr_en = 1'b0; wr_done = 1'b1; rd_done = 1'b1;
        tick();
        wr_done = 1'b0; rd_done = 1'b0;
        check_eq("both_full_cnt", full_cnt, 3'd1);
        check_eq("both_wr_bank", wr_bank, 2'd2);
        check_eq("both_rd_bank", rd_bank, 2'd1);
        check_eq("both_rd_ready", rd_ready, 1'b1);

        // clear at sweep counter 7 with a read in flight
        begin
            int w = 0;
            while (!clr_busy && w < 8) begin tick(); w++; end
        end
        check_eq("pre_clear_busy", clr_busy, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        clear = 1'b1; rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        clear = 1'b0; rd_en = 1'b0;
        check_eq("clr_dout_valid", dout_valid, 1'b0);
        check_eq("clr_wr_bank", wr_bank, 2'd0);
        check_eq("clr_rd_bank", rd_bank, 2'd0);
        check_eq("clr_full_cnt", full_cnt, 3'd0);
        check_eq("clr_wr_ready", wr_ready, 1'b0);
        check_eq("clr_rd_ready", rd_ready, 1'b0);
        measure_busy(n, seen);
        check_eq("clr_sweep_len", n, 16);
        check_eq("clr_after_wr_ready", wr_ready, 1'b1);
        check_eq("clr_after_busy", clr_busy, 1'b0);

        // bank1 (held 0x77 at addr9) must have been scrubbed too
        fill_bank(8'h00, 0);
        fill_bank(8'h00, 0);
        read_at(4'd0, 1'b1);
        read_at(4'd9, 1'b0);
        check_eq("clr_b1_a9", dout, 8'h00);
        check_eq("clr_b1_valid", dout_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
